// File: rtl/rtc_pkg.sv
// Shared types, field widths and calendar helpers for the RTC calendar controller.
// The helpers are pure functions so the same month-length rules serve RTL and bench.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 14;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEC_W-1:0]  sec;
        logic [MIN_W-1:0]  min;
        logic [HOUR_W-1:0] hour;
        logic [DAY_W-1:0]  day;
        logic [MON_W-1:0]  mon;
        logic [YEAR_W-1:0] year;
    } cal_t;

    // Divisions are by constants only, so they reduce to fixed logic.
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return (year[1:0] == 2'b00) &&
               (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0]  mon,
                                                       input logic [YEAR_W-1:0] year);
        logic [DAY_W-1:0] dim;
        case (mon)
            MON_W'(4), MON_W'(6), MON_W'(9), MON_W'(11): dim = DAY_W'(30);
            MON_W'(2): dim = is_leap(year) ? DAY_W'(29) : DAY_W'(28);
            default:   dim = DAY_W'(31);
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/rtc_field_validate.sv
// Combinational legality check of a candidate calendar load.
// The day is checked against the month length of the candidate month and year.
module rtc_field_validate
    import rtc_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 9999
) (
    input  logic [SEC_W-1:0]  sec,
    input  logic [MIN_W-1:0]  min,
    input  logic [HOUR_W-1:0] hour,
    input  logic [DAY_W-1:0]  day,
    input  logic [MON_W-1:0]  mon,
    input  logic [YEAR_W-1:0] year,
    output logic              ok
);

    localparam logic [YEAR_W-1:0] YEAR_MAX_V = YEAR_W'(YEAR_MAX);

    logic mon_ok;
    logic day_ok;

    assign mon_ok = (mon >= MON_W'(1)) && (mon <= MON_W'(12));
    assign day_ok = (day >= DAY_W'(1)) && (day <= days_in_month(mon, year));

    assign ok = (sec < SEC_W'(60)) && (min < MIN_W'(60)) && (hour < HOUR_W'(24)) &&
                mon_ok && day_ok && (year <= YEAR_MAX_V);

endmodule

// File: rtl/rtc_calendar_ctrl.sv
// Calendar time-keeper: advances sec..year on a 1 Hz tick and accepts validated
// loads through a two-state (RUN/CHECK) handshake; a load always wins over a tick.
module rtc_calendar_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned RESET_YEAR = 2000,
    parameter int unsigned YEAR_MAX   = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              run_en,
    input  logic              set_valid,
    input  logic [SEC_W-1:0]  set_sec,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [MON_W-1:0]  set_mon,
    input  logic [YEAR_W-1:0] set_year,
    output logic              set_ready,
    output logic              set_ack,
    output logic              set_err,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  mon,
    output logic [YEAR_W-1:0] year,
    output logic              upd
);

    localparam logic [YEAR_W-1:0] YEAR_MAX_V = YEAR_W'(YEAR_MAX);
    localparam cal_t RESET_CAL = '{
        sec:  '0,
        min:  '0,
        hour: '0,
        day:  DAY_W'(1),
        mon:  MON_W'(1),
        year: YEAR_W'(RESET_YEAR)
    };

    state_t state;
    cal_t   cur;
    cal_t   cur_inc;
    cal_t   shadow;
    logic   tick_pend;
    logic   load_ok;
    logic   tick_live;

    assign tick_live = tick_1hz & run_en;

    rtc_field_validate #(
        .YEAR_MAX (YEAR_MAX)
    ) u_validate (
        .sec  (shadow.sec),
        .min  (shadow.min),
        .hour (shadow.hour),
        .day  (shadow.day),
        .mon  (shadow.mon),
        .year (shadow.year),
        .ok   (load_ok)
    );

    // Out-of-range values compare as at-limit (>=) so a corrupted field still rolls over.
    always_comb begin
        logic c_min, c_hour, c_day, c_mon, c_year;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_inc = cur;
        c_min   = (cur.sec >= SEC_W'(59));
        c_hour  = c_min && (cur.min >= MIN_W'(59));
        c_day   = c_hour && (cur.hour >= HOUR_W'(23));
        c_mon   = c_day && (cur.day >= days_in_month(cur.mon, cur.year));
        c_year  = c_mon && (cur.mon >= MON_W'(12));

        cur_inc.sec = c_min ? '0 : cur.sec + SEC_W'(1);
        if (c_min)  cur_inc.min  = (cur.min  >= MIN_W'(59))  ? '0 : cur.min  + MIN_W'(1);
        if (c_hour) cur_inc.hour = (cur.hour >= HOUR_W'(23)) ? '0 : cur.hour + HOUR_W'(1);
        if (c_day)  cur_inc.day  = c_mon ? DAY_W'(1) : cur.day + DAY_W'(1);
        if (c_mon)  cur_inc.mon  = c_year ? MON_W'(1) : cur.mon + MON_W'(1);
        if (c_year) cur_inc.year = (cur.year >= YEAR_MAX_V) ? '0 : cur.year + YEAR_W'(1);
    end

    // NOTE: the shadow load is data-only and is read solely in S_CHECK, which is
    // entered only after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_RUN && set_valid) begin
            shadow <= '{sec: set_sec, min: set_min, hour: set_hour,
                        day: set_day, mon: set_mon, year: set_year};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            cur       <= RESET_CAL;
            tick_pend <= 1'b0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            upd       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in
            // the same block, which is how the one-cycle pulses are formed.
            set_ack <= 1'b0;
            set_err <= 1'b0;
            upd     <= 1'b0;
            case (state)
                S_RUN: begin
                    if (set_valid) begin
                        state     <= S_CHECK;
                        tick_pend <= tick_pend | tick_live;
                    end else begin
                        tick_pend <= 1'b0;
                        if (run_en && (tick_1hz || tick_pend)) begin
                            cur <= cur_inc;
                            upd <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    state <= S_RUN;
                    if (load_ok) begin
                        cur       <= shadow;
                        set_ack   <= 1'b1;
                        upd       <= 1'b1;
                        tick_pend <= 1'b0;
                    end else begin
                        set_err   <= 1'b1;
                        tick_pend <= tick_pend | tick_live;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign set_ready = (state == S_RUN);
    assign sec       = cur.sec;
    assign min       = cur.min;
    assign hour      = cur.hour;
    assign day       = cur.day;
    assign mon       = cur.mon;
    assign year      = cur.year;

endmodule

// File: tb/tb_rtc_calendar_ctrl.sv
// Scoreboard bench for rtc_calendar_ctrl: stimulus pushes hand-computed events,
// a negedge monitor pops and compares whenever set_ack, set_err or upd fires.
module tb_rtc_calendar_ctrl;
    import rtc_pkg::*;

    typedef struct packed {
        logic ack;
        logic err;
        logic upd;
        cal_t t;
    } ev_t;

    logic              clk;
    logic              rst;
    logic              tick_1hz;
    logic              run_en;
    logic              set_valid;
    logic [SEC_W-1:0]  set_sec;
    logic [MIN_W-1:0]  set_min;
    logic [HOUR_W-1:0] set_hour;
    logic [DAY_W-1:0]  set_day;
    logic [MON_W-1:0]  set_mon;
    logic [YEAR_W-1:0] set_year;
    logic              set_ready;
    logic              set_ack;
    logic              set_err;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic [DAY_W-1:0]  day;
    logic [MON_W-1:0]  mon;
    logic [YEAR_W-1:0] year;
    logic              upd;
    cal_t              dut_t;

    int n_checks = 0;
    int n_pass   = 0;
    ev_t exp_q[$];

    rtc_calendar_ctrl #(
        .RESET_YEAR (2000),
        .YEAR_MAX   (9999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .run_en    (run_en),
        .set_valid (set_valid),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_day   (set_day),
        .set_mon   (set_mon),
        .set_year  (set_year),
        .set_ready (set_ready),
        .set_ack   (set_ack),
        .set_err   (set_err),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .mon       (mon),
        .year      (year),
        .upd       (upd)
    );

    assign dut_t = {sec, min, hour, day, mon, year};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cal_t mk(input int h, input int m, input int s,
                                input int d, input int mo, input int y);
        cal_t t;
        t.sec  = SEC_W'(s);
        t.min  = MIN_W'(m);
        t.hour = HOUR_W'(h);
        t.day  = DAY_W'(d);
        t.mon  = MON_W'(mo);
        t.year = YEAR_W'(y);
        return t;
    endfunction

    function automatic ev_t ev(input logic a, input logic e, input logic u, input cal_t t);
        ev_t x;
        x.ack = a;
        x.err = e;
        x.upd = u;
        x.t   = t;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic exp_upd);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("tick_upd_latency", 64'(upd), 64'(exp_upd));
    endtask

    task automatic load(input cal_t t, input logic tick_cap, input logic tick_chk);
        check("ready_before_load", 64'(set_ready), 64'(1));
        set_valid = 1'b1;
        set_sec   = t.sec;
        set_min   = t.min;
        set_hour  = t.hour;
        set_day   = t.day;
        set_mon   = t.mon;
        set_year  = t.year;
        tick_1hz  = tick_cap;
        step();
        set_valid = 1'b0;
        tick_1hz  = tick_chk;
        check("ready_in_check", 64'(set_ready), 64'(0));
        step();
        tick_1hz = 1'b0;
    endtask

    // Monitor: every output event must match the oldest expected event.
    initial begin
        ev_t obs;
        ev_t want;
        forever begin
            @(negedge clk);
            if (!rst && (set_ack || set_err || upd)) begin
                obs = ev(set_ack, set_err, upd, dut_t);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(obs), 64'(0));
                end else begin
                    want = exp_q.pop_front();
                    check("event", 64'(obs), 64'(want));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   leap_y[3]  = '{2024, 1900, 2000};
        int   leap_d[3]  = '{29, 1, 29};
        int   leap_m[3]  = '{2, 3, 2};
        cal_t bad[5];
        cal_t cur_exp;
        int   wait_n;

        rst = 1'b1; tick_1hz = 1'b0; run_en = 1'b0; set_valid = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0; set_day = '0; set_mon = '0; set_year = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_time",  64'(dut_t),     64'(mk(0, 0, 0, 1, 1, 2000)));
        check("reset_ready", 64'(set_ready), 64'(1));
        check("reset_pulses", 64'({set_ack, set_err, upd}), 64'(0));

        // Frozen: ticks dropped while run_en=0
        repeat (3) do_tick(1'b0);
        check("frozen_time", 64'(dut_t), 64'(mk(0, 0, 0, 1, 1, 2000)));
        run_en = 1'b1;

        // Year rollover
        exp_q.push_back(ev(1, 0, 1, mk(23, 59, 59, 31, 12, 2023)));
        load(mk(23, 59, 59, 31, 12, 2023), 1'b0, 1'b0);
        exp_q.push_back(ev(0, 0, 1, mk(0, 0, 0, 1, 1, 2024)));
        do_tick(1'b1);

        // Leap-year February end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev(1, 0, 1, mk(23, 59, 59, 28, 2, leap_y[i])));
            load(mk(23, 59, 59, 28, 2, leap_y[i]), 1'b0, 1'b0);
            exp_q.push_back(ev(0, 0, 1, mk(0, 0, 0, leap_d[i], leap_m[i], leap_y[i])));
            do_tick(1'b1);
        end

        // Illegal loads: time unchanged, no upd
        cur_exp = mk(0, 0, 0, 29, 2, 2000);
        bad[0] = mk(0, 0, 0, 31, 4, 2023);
        bad[1] = mk(0, 0, 0, 29, 2, 2023);
        bad[2] = mk(24, 0, 0, 1, 1, 2023);
        bad[3] = mk(0, 0, 0, 1, 0, 2023);
        bad[4] = mk(0, 0, 0, 1, 1, 10000);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ev(0, 1, 0, cur_exp));
            load(bad[i], 1'b0, 1'b0);
        end

        // Load wins over a tick in the capture cycle and in the check cycle
        exp_q.push_back(ev(1, 0, 1, mk(10, 20, 30, 15, 6, 2023)));
        load(mk(10, 20, 30, 15, 6, 2023), 1'b1, 1'b0);
        repeat (3) step();
        exp_q.push_back(ev(1, 0, 1, mk(11, 0, 0, 1, 7, 2023)));
        load(mk(11, 0, 0, 1, 7, 2023), 1'b0, 1'b1);
        repeat (3) step();
        check("load_exact", 64'(dut_t), 64'(mk(11, 0, 0, 1, 7, 2023)));

        // Rejected load: pended tick merges with a new tick into one second
        exp_q.push_back(ev(0, 1, 0, mk(11, 0, 0, 1, 7, 2023)));
        exp_q.push_back(ev(0, 0, 1, mk(11, 0, 1, 1, 7, 2023)));
        load(bad[1], 1'b1, 1'b0);
        do_tick(1'b1);
        repeat (3) step();
        // Rejected load: tick during the check cycle is pended and applied next
        exp_q.push_back(ev(0, 1, 0, mk(11, 0, 1, 1, 7, 2023)));
        exp_q.push_back(ev(0, 0, 1, mk(11, 0, 2, 1, 7, 2023)));
        load(bad[2], 1'b0, 1'b1);
        repeat (3) step();
        check("pend_once", 64'(dut_t), 64'(mk(11, 0, 2, 1, 7, 2023)));

        // YEAR_MAX wraps to 0
        exp_q.push_back(ev(1, 0, 1, mk(23, 59, 59, 31, 12, 9999)));
        load(mk(23, 59, 59, 31, 12, 9999), 1'b0, 1'b0);
        exp_q.push_back(ev(0, 0, 1, mk(0, 0, 0, 1, 1, 0)));
        do_tick(1'b1);

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 10) begin
            step();
            wait_n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        // Reset during S_CHECK discards the load
        set_valid = 1'b1;
        set_sec = 6'd5; set_min = 6'd5; set_hour = 5'd5;
        set_day = 5'd5; set_mon = 4'd5; set_year = 14'd2005;
        step();
        set_valid = 1'b0;
        check("ready_in_check_rst", 64'(set_ready), 64'(0));
        #2 rst = 1'b1;
        #1;
        check("rst_async_time",  64'(dut_t),     64'(mk(0, 0, 0, 1, 1, 2000)));
        check("rst_async_ready", 64'(set_ready), 64'(1));
        step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_after_time", 64'(dut_t), 64'(mk(0, 0, 0, 1, 1, 2000)));
        check("rst_no_events",  64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
